// File: rtl/conv_window_reader.sv
// conv_window_reader
//   Read-side companion to the image/filter memory. On a rising edge of
//   done_memory (while idle) it snapshots the IMG_DIM x IMG_DIM image and the
//   K_DIM x K_DIM filter. It then streams every valid convolution window as
//   K_DIM^2 (pixel, weight) taps over a valid/ready handshake, and finishes
//   with a one-cycle done_read pulse.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   done_memory       a 0->1 transition while idle starts a read pass
//   img_bus, flt_bus  row-major packed image / filter, element n at [n*DATA_W +: DATA_W]
//   pix_out, wgt_out  current tap pixel / weight (0 when no tap is presented)
//   tap_valid/ready   tap handshake; a transfer happens on valid & ready
//   tap_first/last    tap 0 / tap K_DIM^2-1 of a window (qualified by valid)
//   win_idx           current window, row-major (0 outside streaming)
//   busy              high whenever a pass is in progress
//   done_read         one-cycle pulse at the end of a pass
module conv_window_reader #(
   parameter  int DATA_W  = 8,
   parameter  int IMG_DIM = 4,
   parameter  int K_DIM   = 3,
   localparam int OUT_DIM = IMG_DIM - K_DIM + 1,
   localparam int NWIN    = OUT_DIM * OUT_DIM,
   localparam int WIN_W   = ($clog2(NWIN) < 1) ? 1 : $clog2(NWIN)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               done_memory,
   input  logic [IMG_DIM*IMG_DIM*DATA_W-1:0]  img_bus,
   input  logic [K_DIM*K_DIM*DATA_W-1:0]      flt_bus,
   output logic [DATA_W-1:0]                  pix_out,
   output logic [DATA_W-1:0]                  wgt_out,
   output logic                               tap_valid,
   input  logic                               tap_ready,
   output logic                               tap_first,
   output logic                               tap_last,
   output logic [WIN_W-1:0]                   win_idx,
   output logic                               busy,
   output logic                               done_read
);

   localparam int NPIX  = IMG_DIM * IMG_DIM;
   localparam int NTAP  = K_DIM * K_DIM;
   localparam int PIX_W = ($clog2(NPIX) < 1) ? 1 : $clog2(NPIX);
   localparam int TAP_W = ($clog2(NTAP) < 1) ? 1 : $clog2(NTAP);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               done_dly_q, done_dly_d;   // previous done_memory, for edge detect
   logic [WIN_W-1:0]   win_q, win_d;
   logic [TAP_W-1:0]   tap_q, tap_d;
   logic [DATA_W-1:0]  img_q [NPIX];
   logic [DATA_W-1:0]  img_d [NPIX];
   logic [DATA_W-1:0]  flt_q [NTAP];
   logic [DATA_W-1:0]  flt_d [NTAP];

   // Unpack the flat input buses into element arrays.
   logic [DATA_W-1:0]  img_in [NPIX];
   logic [DATA_W-1:0]  flt_in [NTAP];

   for (genvar g = 0; g < NPIX; g++) begin : g_img
      assign img_in[g] = img_bus[g*DATA_W +: DATA_W];
   end
   for (genvar g = 0; g < NTAP; g++) begin : g_flt
      assign flt_in[g] = flt_bus[g*DATA_W +: DATA_W];
   end

   logic start, streaming, last_tap, last_win;

   assign streaming = (state_q == S_STREAM);
   assign start     = done_memory & ~done_dly_q & (state_q == S_IDLE);
   assign last_tap  = (tap_q == TAP_W'(NTAP - 1));
   assign last_win  = (win_q == WIN_W'(NWIN - 1));

   // Next-state / counter / snapshot logic.
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      tap_d      = tap_q;
      img_d      = img_q;
      flt_d      = flt_q;
      done_dly_d = done_memory;   // tracks the input in every state
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_STREAM;
               win_d   = '0;
               tap_d   = '0;
               img_d   = img_in;
               flt_d   = flt_in;
            end
         end
         S_STREAM: begin
            if (tap_ready) begin
               if (last_tap) begin
                  tap_d = '0;
                  if (last_win) begin
                     // Leave counters at zero so the next pass starts clean.
                     win_d   = '0;
                     state_d = S_FINISH;
                  end else begin
                     win_d = win_q + 1'b1;
                  end
               end else begin
                  tap_d = tap_q + 1'b1;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         done_dly_q <= 1'b1;   // a level already high at reset release is not an edge
         win_q      <= '0;
         tap_q      <= '0;
         for (int i = 0; i < NPIX; i++) img_q[i] <= '0;
         for (int i = 0; i < NTAP; i++) flt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         done_dly_q <= done_dly_d;
         win_q      <= win_d;
         tap_q      <= tap_d;
         img_q      <= img_d;
         flt_q      <= flt_d;
      end
   end

   // Window/tap to pixel address: ((wr+kr)*IMG_DIM + (wc+kc)).
   int unsigned wr, wc, kr, kc;
   logic [PIX_W-1:0] pix_idx;

   always_comb begin
      wr      = 32'(win_q) / OUT_DIM;
      wc      = 32'(win_q) % OUT_DIM;
      kr      = 32'(tap_q) / K_DIM;
      kc      = 32'(tap_q) % K_DIM;
      pix_idx = PIX_W'((wr + kr) * IMG_DIM + wc + kc);
   end

   // Outputs depend only on registered state; nothing combinational from tap_ready.
   assign tap_valid = streaming;
   assign pix_out   = streaming ? img_q[pix_idx] : '0;
   assign wgt_out   = streaming ? flt_q[tap_q]   : '0;
   assign tap_first = streaming & (tap_q == '0);
   assign tap_last  = streaming & last_tap;
   assign win_idx   = streaming ? win_q : '0;
   assign busy      = (state_q != S_IDLE);
   assign done_read = (state_q == S_FINISH);

endmodule

// File: tb/tb_conv_window_reader.sv
// Randomized scoreboard bench for conv_window_reader. The driver issues
// passes and pushes the expected tap sequence (computed from window/kernel
// geometry) plus the start edge into queues; a negedge monitor pops and
// compares whenever a tap transfers or done_read appears.
module tb_conv_window_reader;

   localparam int DW = 8;
   localparam int ID = 4;
   localparam int KD = 3;
   localparam int OD = ID - KD + 1;
   localparam int NP = ID * ID;
   localparam int NT = KD * KD;
   localparam int NW = OD * OD;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              done_memory = 1'b0;
   logic              tap_ready = 1'b0;
   logic [NP*DW-1:0]  img_bus = '0;
   logic [NT*DW-1:0]  flt_bus = '0;
   logic [DW-1:0]     pix_out, wgt_out;
   logic              tap_valid, tap_first, tap_last, busy, done_read;
   logic [1:0]        win_idx;

   conv_window_reader #(.DATA_W(DW), .IMG_DIM(ID), .K_DIM(KD)) dut (
      .clk(clk), .rst(rst), .done_memory(done_memory),
      .img_bus(img_bus), .flt_bus(flt_bus),
      .pix_out(pix_out), .wgt_out(wgt_out),
      .tap_valid(tap_valid), .tap_ready(tap_ready),
      .tap_first(tap_first), .tap_last(tap_last),
      .win_idx(win_idx), .busy(busy), .done_read(done_read)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   typedef struct {
      logic [7:0] pix;
      logic [7:0] wgt;
      bit         first;
      bit         last;
      int         win;
   } tap_t;

   tap_t tap_q[$];
   int   start_q[$];
   int   done_cnt = 0;
   int   stall_cnt = 0;
   int   exp_passes = 0;

   logic [7:0] img_m [NP];
   logic [7:0] flt_m [NT];

   // ---------------- monitor ----------------
   bit          prev_valid = 1'b0;
   bit          prev_ready = 1'b0;
   logic [19:0] prev_bits = '0;
   tap_t        mon_e;
   int          mon_s;

   always @(negedge clk) begin
      if (!rst) begin
         chk("reset_outputs_zero",
             {pix_out, wgt_out, tap_valid, tap_first, tap_last, win_idx, busy, done_read}, 0);
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         stall_cnt  = 0;
      end else begin
         if (tap_valid && !prev_valid) begin
            if (start_q.size() == 0) chk("spurious_start", 1, 0);
            else chk("start_latency", cyc, start_q[0]);
         end
         if (prev_valid && !prev_ready) begin
            chk("stall_valid_held", tap_valid, 1);
            chk("stall_stable", {pix_out, wgt_out, tap_first, tap_last, win_idx}, prev_bits);
         end
         if (tap_valid && tap_ready) begin
            if (tap_q.size() == 0) chk("extra_tap", 1, 0);
            else begin
               mon_e = tap_q.pop_front();
               chk("pix_out", pix_out, mon_e.pix);
               chk("wgt_out", wgt_out, mon_e.wgt);
               chk("tap_first", tap_first, mon_e.first);
               chk("tap_last", tap_last, mon_e.last);
               chk("win_idx", win_idx, mon_e.win);
               chk("busy_stream", busy, 1);
            end
         end
         if (tap_valid && !tap_ready) stall_cnt++;
         if (done_read) begin
            if (start_q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               mon_s = start_q.pop_front();
               chk("done_cycle", cyc, mon_s + NW * NT + stall_cnt);
               chk("taps_left_at_done", tap_q.size(), 0);
               chk("busy_finish", busy, 1);
               chk("finish_idle_outputs", {tap_valid, win_idx}, 0);
            end
            stall_cnt = 0;
            done_cnt++;
         end
         prev_valid = tap_valid;
         prev_ready = tap_ready;
         prev_bits  = {pix_out, wgt_out, tap_first, tap_last, win_idx};
      end
   end

   // ---------------- model / driver ----------------
   task automatic set_base();
      for (int n = 0; n < NP; n++) img_m[n] = 8'(8'h10 + n);
      for (int n = 0; n < NT; n++) flt_m[n] = 8'(8'h20 + n);
      img_m[0]  = 8'hD5;
      img_m[1]  = 8'h37;
      img_m[4]  = 8'h65;
      img_m[5]  = 8'hEA;
      img_m[15] = 8'hAA;
      flt_m[0]  = 8'h3C;
      flt_m[4]  = 8'hE3;
      flt_m[8]  = 8'h56;
   endtask

   task automatic set_random();
      for (int n = 0; n < NP; n++) img_m[n] = 8'($urandom);
      for (int n = 0; n < NT; n++) flt_m[n] = 8'($urandom);
   endtask

   // Every window (row-major) and within it every kernel position (row-major).
   task automatic push_expected();
      tap_t e;
      for (int wr = 0; wr < OD; wr++)
         for (int wc = 0; wc < OD; wc++)
            for (int kr = 0; kr < KD; kr++)
               for (int kc = 0; kc < KD; kc++) begin
                  e.pix   = img_m[(wr + kr) * ID + (wc + kc)];
                  e.wgt   = flt_m[kr * KD + kc];
                  e.first = (kr == 0 && kc == 0);
                  e.last  = (kr == KD - 1 && kc == KD - 1);
                  e.win   = wr * OD + wc;
                  tap_q.push_back(e);
               end
   endtask

   task automatic begin_pass(output int s);
      @(posedge clk); #1;
      done_memory = 1'b0;
      @(posedge clk); #1;
      for (int n = 0; n < NP; n++) img_bus[n*DW +: DW] = img_m[n];
      for (int n = 0; n < NT; n++) flt_bus[n*DW +: DW] = flt_m[n];
      push_expected();
      done_memory = 1'b1;
      s = cyc + 1;
      start_q.push_back(s);
      tap_ready = 1'b1;
      exp_passes++;
   endtask

   // mode 0: ready held 1; 1: random ready; 2: five-cycle stall at w1 t3.
   task automatic do_pass(input int mode, input bit clobber);
      int s, target;
      begin_pass(s);
      target = done_cnt + 1;
      for (int i = 0; i < 400 && done_cnt < target; i++) begin
         @(posedge clk); #1;
         if (clobber && cyc == s) begin
            img_bus = '1;
            flt_bus = '1;
         end
         case (mode)
            1:       tap_ready = ($urandom_range(0, 3) != 0);
            2:       tap_ready = !(cyc >= s + 12 && cyc <= s + 16);
            default: tap_ready = 1'b1;
         endcase
      end
      chk("pass_completed", done_cnt, target);
      tap_ready = 1'b1;
   endtask

   initial begin
      int s, dc;
      // Reset held low with inputs toggling; monitor checks outputs are 0.
      #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         done_memory = 1'($urandom);
         tap_ready   = 1'($urandom);
         img_bus     = {4{$urandom}};
         flt_bus     = {$urandom, $urandom, 8'($urandom)};
      end
      done_memory = 1'b1;
      tap_ready   = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("no_start_after_reset_busy", busy, 0);
      chk("no_start_after_reset_done", done_cnt, 0);

      // Full pass with the reference vector, ready held high.
      set_base();
      do_pass(0, 1'b0);

      // Backpressure at w1 t3.
      do_pass(2, 1'b0);

      // Snapshot: buses overwritten one cycle after start.
      set_random();
      do_pass(0, 1'b1);

      // Retrigger: done_memory still high after the pass -> nothing new.
      dc = done_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("retrigger_level_busy", busy, 0);
      chk("retrigger_level_done", done_cnt, dc);
      set_base();
      do_pass(0, 1'b0);

      // Reset mid-pass at w2 t5.
      begin_pass(s);
      for (int i = 0; i < 100 && cyc < s + 23; i++) begin
         @(posedge clk); #1;
      end
      chk("at_w2_t5", {win_idx, tap_valid}, {2'd2, 1'b1});
      rst = 1'b0;
      #1;
      chk("async_reset_outputs",
          {pix_out, wgt_out, tap_valid, tap_first, tap_last, win_idx, busy, done_read}, 0);
      tap_q.delete();
      start_q.delete();
      exp_passes--;
      dc = done_cnt;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("no_done_after_abort", done_cnt, dc);
      chk("idle_after_abort", busy, 0);
      do_pass(0, 1'b0);

      // Random data with random backpressure.
      for (int p = 0; p < 4; p++) begin
         set_random();
         do_pass(1, p[0]);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("taps_remaining", tap_q.size(), 0);
      chk("starts_remaining", start_q.size(), 0);
      chk("pass_count", done_cnt, exp_passes);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
